// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage
// Decode pipeline stage sitting directly behind instruction fetch. Fetched
// words are either bypassed straight into the output register or parked in a
// small skid queue, then split into class / register / immediate fields.
// A load-use hazard against the word currently in the output register costs
// exactly one bubble; a flush discards the queue and the output word.
//
// Ports
//   clock          pipeline clock
//   reset_n        synchronous active-low reset
//   in_valid       fetch word valid this cycle
//   in_instruction fetched instruction word
//   in_pc          PC of the fetched word
//   in_hold        back-pressure to fetch (fetch reacts one cycle later)
//   flush          PC change: drop queue contents, output and incoming word
//   out_hold       execute stall
//   out_valid      decoded instruction valid
//   out_pc         PC of decoded instruction
//   out_class      instruction[31:28]
//   out_rd/ra/rb   register indices [27:23] / [22:18] / [17:13]
//   out_imm        instruction[12:0] sign-extended to WIDTH
//   out_is_load    out_class == 4'h4
module decode_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_instruction,
    input  logic [WIDTH-1:0]    in_pc,
    output logic                in_hold,
    input  logic                flush,
    input  logic                out_hold,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_pc,
    output logic [3:0]          out_class,
    output logic [REG_BITS-1:0] out_rd,
    output logic [REG_BITS-1:0] out_ra,
    output logic [REG_BITS-1:0] out_rb,
    output logic [WIDTH-1:0]    out_imm,
    output logic                out_is_load
);

    localparam int         PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CNT_W      = $clog2(DEPTH + 1);
    localparam logic [3:0] CLASS_LOAD = 4'h4;

    function automatic logic signed [WIDTH-1:0] sign_ext_imm(input logic [WIDTH-1:0] instr);
        return {{(WIDTH-13){instr[12]}}, instr[12:0]};
    endfunction

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [WIDTH-1:0]    q_instr [DEPTH];
    logic [WIDTH-1:0]    q_pc    [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                vld_p1;
    logic [WIDTH-1:0]    pc_p1;
    logic [3:0]          class_p1;
    logic [REG_BITS-1:0] rd_p1;
    logic [REG_BITS-1:0] ra_p1;
    logic [REG_BITS-1:0] rb_p1;
    logic signed [WIDTH-1:0] imm_p1;
    logic                is_load_p1;

    logic                q_empty;
    logic                q_full;
    logic                advance;
    logic                src_valid;
    logic [WIDTH-1:0]    src_instr;
    logic [WIDTH-1:0]    src_pc;
    logic [REG_BITS-1:0] src_ra;
    logic [REG_BITS-1:0] src_rb;
    logic                hazard;
    logic                load_src;
    logic                pop;
    logic                push;
    logic                push_ok;

    assign q_empty = (count == '0);
    assign q_full  = (count == CNT_W'(DEPTH));

    // Raised one entry early: fetch sees hold a cycle late and may still
    // deliver one more word, which lands in the last free slot.
    assign in_hold = (count >= CNT_W'(DEPTH - 1));

    assign advance   = !vld_p1 || !out_hold;
    assign src_valid = !q_empty || in_valid;
    assign src_instr = q_empty ? in_instruction : q_instr[rd_ptr];
    assign src_pc    = q_empty ? in_pc          : q_pc[rd_ptr];
    assign src_ra    = src_instr[22 -: REG_BITS];
    assign src_rb    = src_instr[17 -: REG_BITS];

    // r0 is never a real destination, so a load to r0 cannot create a hazard.
    assign hazard = vld_p1 && is_load_p1 && (rd_p1 != '0) &&
                    ((src_ra == rd_p1) || (src_rb == rd_p1));

    assign load_src = advance && src_valid && !hazard;
    assign pop      = load_src && !q_empty;
    // An incoming word is queued unless it was bypassed straight to the output
    // (this includes the hazard case, where the bypass candidate is parked).
    assign push     = in_valid && !flush && !(load_src && q_empty);
    assign push_ok  = push && (!q_full || pop);

    // ---- stage 0: skid queue control ----
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            q_instr[wr_ptr] <= in_instruction;
            q_pc[wr_ptr]    <= in_pc;
        end
    end

    // ---- stage 1: decoded output register ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            class_p1   <= '0;
            rd_p1      <= '0;
            ra_p1      <= '0;
            rb_p1      <= '0;
            imm_p1     <= '0;
            is_load_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= load_src;
            if (load_src) begin
                pc_p1      <= src_pc;
                class_p1   <= src_instr[31:28];
                rd_p1      <= src_instr[27 -: REG_BITS];
                ra_p1      <= src_ra;
                rb_p1      <= src_rb;
                imm_p1     <= sign_ext_imm(src_instr);
                is_load_p1 <= (src_instr[31:28] == CLASS_LOAD);
            end
        end
    end

    assign out_valid   = vld_p1;
    assign out_pc      = pc_p1;
    assign out_class   = class_p1;
    assign out_rd      = rd_p1;
    assign out_ra      = ra_p1;
    assign out_rb      = rb_p1;
    assign out_imm     = imm_p1;
    assign out_is_load = is_load_p1;

    // A word arriving with the queue full is lost; fetch must honour in_hold.
    overflow_check: assert property (@(posedge clock) disable iff (!reset_n)
                                     !(push && !push_ok));

endmodule
